// File: rtl/router_pkt_fsm.sv
// router_pkt_fsm: ingress controller of the 1x3 router.
// Takes a header/payload/parity byte stream from the source, steers it into
// the destination FIFO chosen by the header, raises lfd_state one cycle
// ahead of the header write, back-pressures the source with busy and checks
// the packet's even-XOR parity. Addresses at or above NUM_DEST are dropped
// and flagged as errors.
module router_pkt_fsm #(
  parameter int NUM_DEST = 3
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                pkt_valid_i,
  input  logic [7:0]          data_in_i,
  input  logic [NUM_DEST-1:0] fifo_full_i,
  input  logic [NUM_DEST-1:0] fifo_empty_i,
  output logic [7:0]          dout_o,
  output logic [NUM_DEST-1:0] write_enb_o,
  output logic                lfd_state_o,
  output logic                busy_o,
  output logic                err_o,
  output logic                parity_done_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    LFD,
    HDR_WR,
    DATA,
    CHECK,
    DROP
  } state_t;

  state_t      state_q;
  logic [7:0]  hdrReg_q;
  logic [1:0]  addr_q;
  logic [6:0]  rem_q;
  logic [7:0]  par_q;
  logic        err_q;
  logic        lfd_q;
  logic        hdrWr_q;
  logic        parityDone_q;
  logic        busy_q;

  logic [3:0]  fullPad;
  logic [3:0]  emptyPad;
  logic [3:0]  selPad;
  logic [1:0]  hdrAddr;
  logic        hdrInvalid;
  logic        hdrEmpty;
  logic        destFull;
  logic        destEmpty;
  logic        accept;
  logic        dataWrite;
  logic        hdrWrite;

  // The flag vectors are widened to cover every 2-bit address so an
  // out-of-range header address reads as "not empty / not full" safely.
  always_comb begin
    fullPad    = {{(4 - NUM_DEST){1'b0}}, fifo_full_i};
    emptyPad   = {{(4 - NUM_DEST){1'b0}}, fifo_empty_i};
    hdrAddr    = data_in_i[1:0];
    hdrInvalid = ({1'b0, hdrAddr} >= 3'(NUM_DEST));
    hdrEmpty   = emptyPad[hdrAddr];
    destFull   = fullPad[addr_q];
    destEmpty  = emptyPad[addr_q];
    selPad     = 4'b0001 << addr_q;
  end

  // Busy follows the selected FIFO's full flag live while streaming payload;
  // in every other state it comes from the registered Moore value.
  always_comb begin
    busy_o    = busy_q;
    if (state_q == DATA) begin
      busy_o = destFull;
    end
    accept    = pkt_valid_i & ~busy_o;
    dataWrite = (state_q == DATA) & accept;
    hdrWrite  = hdrWr_q & ~destFull;
  end

  // Shared FIFO bus: idle at zero, carries the header in HDR_WR and the
  // source byte on every accepted payload/parity byte.
  always_comb begin
    dout_o      = 8'h00;
    write_enb_o = '0;
    if (dataWrite) begin
      dout_o      = data_in_i;
      write_enb_o = selPad[NUM_DEST-1:0];
    end else if (hdrWrite) begin
      dout_o      = hdrReg_q;
      write_enb_o = selPad[NUM_DEST-1:0];
    end
  end

  // Packet FSM with header capture, length countdown, running parity and
  // the registered lfd/header-write/parity-done/busy outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      hdrReg_q     <= 8'h00;
      addr_q       <= 2'd0;
      rem_q        <= 7'd0;
      par_q        <= 8'h00;
      err_q        <= 1'b0;
      lfd_q        <= 1'b0;
      hdrWr_q      <= 1'b0;
      parityDone_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      lfd_q        <= 1'b0;
      hdrWr_q      <= 1'b0;
      parityDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            hdrReg_q <= data_in_i;
            addr_q   <= hdrAddr;
            rem_q    <= {1'b0, data_in_i[7:2]} + 7'd1;
            par_q    <= data_in_i;
            if (hdrInvalid) begin
              err_q   <= 1'b1;
              state_q <= DROP;
            end else if (hdrEmpty) begin
              err_q   <= 1'b0;
              lfd_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= LFD;
            end else begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= WAIT_EMPTY;
            end
          end
        end
        WAIT_EMPTY: begin
          if (destEmpty) begin
            lfd_q   <= 1'b1;
            state_q <= LFD;
          end
        end
        LFD: begin
          hdrWr_q <= 1'b1;
          state_q <= HDR_WR;
        end
        HDR_WR: begin
          busy_q  <= 1'b0;
          state_q <= DATA;
        end
        DATA: begin
          if (accept) begin
            rem_q <= rem_q - 7'd1;
            if (rem_q == 7'd1) begin
              err_q        <= (par_q != data_in_i);
              parityDone_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= CHECK;
            end else begin
              par_q <= par_q ^ data_in_i;
            end
          end
        end
        CHECK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        DROP: begin
          if (accept) begin
            rem_q <= rem_q - 7'd1;
            if (rem_q == 7'd1) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign lfd_state_o   = lfd_q;
  assign err_o         = err_q;
  assign parity_done_o = parityDone_q;

endmodule
